// File: rtl/block_mac_2x2.sv
// block_mac_2x2
// 2x2 block multiply-accumulate responder. A rising edge on start_mac,
// seen while idle, captures the A and B operand blocks and computes C = A*B
// with one shared multiplier. The multiplier issues one product per cycle
// for 8 cycles. Results are modulo 2^data_w. The result block is presented
// with a one-cycle done_mac pulse, 10 cycles after the capture edge.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   start_mac                request; only a 0->1 transition while idle starts
//   a_11..a_22, b_11..b_22   operand blocks, sampled at the capture edge
//   c_11..c_22               registered result block, held until the next done
//   done_mac                 one-cycle pulse when c_* update
//   busy                     high from the capture edge through the done cycle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start edge; results and done pulse settle
// MUL   | idx 0..7, one product per cycle into p
// DRAIN | last product folds into its accumulator
// DONE  | accumulators copied to c_*, done_mac pulsed
module block_mac_2x2 #(
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mac,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              done_mac,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t            state;
  logic              start_q;
  logic [2:0]        idx;
  logic [data_w-1:0] opa [4];   // a_11, a_12, a_21, a_22
  logic [data_w-1:0] opb [4];   // b_11, b_12, b_21, b_22
  logic [data_w-1:0] acc [4];   // acc11, acc12, acc21, acc22
  logic [data_w-1:0] p;
  logic [1:0]        p_tgt;
  logic              p_vld;

  logic              trigger;
  logic [data_w-1:0] a_sel;
  logic [data_w-1:0] b_sel;
  logic [data_w-1:0] prod;

  assign trigger = start_mac & ~start_q;

  // Issue order: idx[2] picks the A row, idx[1] picks the B column, and
  // idx[0] walks the inner dimension. The target accumulator is {row, col},
  // so it equals idx[2:1].
  assign a_sel = opa[{idx[2], idx[0]}];
  assign b_sel = opb[{idx[0], idx[1]}];
  // Self-determined width keeps only the low data_w bits of the product.
  assign prod  = a_sel * b_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      idx      <= '0;
      p        <= '0;
      p_tgt    <= '0;
      p_vld    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        opa[i] <= '0;
        opb[i] <= '0;
        acc[i] <= '0;
      end
      c_11     <= '0;
      c_12     <= '0;
      c_21     <= '0;
      c_22     <= '0;
      done_mac <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start_q <= start_mac;

      // The product issued last cycle lands one cycle later.
      if (p_vld) begin
        acc[p_tgt] <= acc[p_tgt] + p;
      end

      case (state)
        IDLE: begin
          done_mac <= 1'b0;
          p_vld    <= 1'b0;
          busy     <= trigger;
          if (trigger) begin
            opa[0] <= a_11;
            opa[1] <= a_12;
            opa[2] <= a_21;
            opa[3] <= a_22;
            opb[0] <= b_11;
            opb[1] <= b_12;
            opb[2] <= b_21;
            opb[3] <= b_22;
            for (int i = 0; i < 4; i++) begin
              acc[i] <= '0;
            end
            idx   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          p     <= prod;
          p_tgt <= idx[2:1];
          p_vld <= 1'b1;
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          p_vld <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          c_11     <= acc[0];
          c_12     <= acc[1];
          c_21     <= acc[2];
          c_22     <= acc[3];
          done_mac <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mac_2x2.sv
module tb_block_mac_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_mac;
  logic [31:0] av [4];
  logic [31:0] bv [4];
  logic [31:0] c_11, c_12, c_21, c_22;
  logic        done_mac, busy;

  int n_pass  = 0;
  int n_total = 0;

  // Operands as captured at the start edge, used by the reference model.
  logic [31:0] ea [4];
  logic [31:0] eb [4];

  always #5 clk = ~clk;

  block_mac_2x2 #(.data_w(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_mac(start_mac),
    .a_11     (av[0]),
    .a_12     (av[1]),
    .a_21     (av[2]),
    .a_22     (av[3]),
    .b_11     (bv[0]),
    .b_12     (bv[1]),
    .b_21     (bv[2]),
    .b_22     (bv[3]),
    .c_11     (c_11),
    .c_12     (c_12),
    .c_21     (c_21),
    .c_22     (c_22),
    .done_mac (done_mac),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      ea[i] = av[i];
      eb[i] = bv[i];
    end
  endtask

  // Plain matrix product C[r][c] = sum_k A[r][k]*B[k][c], modulo 2^32.
  function automatic logic [31:0] ref_c(input int r, input int c);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < 2; k++) begin
      s = s + 64'(ea[r*2+k]) * 64'(eb[k*2+c]);
    end
    return s[31:0];
  endfunction

  task automatic check_c(input string tag);
    chk({tag, "_c11"}, c_11, ref_c(0, 0));
    chk({tag, "_c12"}, c_12, ref_c(0, 1));
    chk({tag, "_c21"}, c_21, ref_c(1, 0));
    chk({tag, "_c22"}, c_22, ref_c(1, 1));
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
  endtask

  // One-cycle start pulse, then watch latency, pulse count and busy width.
  task automatic run_block(input string tag);
    int done_at, done_cnt, busy_cnt;
    snap();
    start_mac = 1'b1;
    tick();
    start_mac = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (done_mac) begin
        done_cnt++;
        done_at = k;
      end
    end
    chk({tag, "_latency"}, 32'(done_at), 32'd10);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_len"}, 32'(busy_cnt), 32'd11);
    check_c(tag);
  endtask

  initial begin
    int done_cnt, done_at;
    rst       = 1'b1;
    start_mac = 1'b0;
    av        = '{32'd0, 32'd0, 32'd0, 32'd0};
    bv        = '{32'd0, 32'd0, 32'd0, 32'd0};
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_mac), 32'd0);
    chk("rst_c11", c_11, 32'd0);
    chk("rst_c22", c_22, 32'd0);
    rst = 1'b0;
    tick();

    // Identity
    av = '{32'd1, 32'd2, 32'd3, 32'd4};
    bv = '{32'd1, 32'd0, 32'd0, 32'd1};
    run_block("ident");

    // General product, plus fixed expected values
    bv = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_block("gen");
    chk("gen_k11", c_11, 32'd19);
    chk("gen_k12", c_12, 32'd22);
    chk("gen_k21", c_21, 32'd43);
    chk("gen_k22", c_22, 32'd50);
    done_cnt = 0;
    repeat (5) begin
      tick();
      if (done_mac) done_cnt++;
    end
    chk("gen_no_pulse", 32'(done_cnt), 32'd0);
    chk("gen_hold_c22", c_22, 32'd50);

    // Wrap / signed
    av = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    bv = '{32'd2, 32'd0, 32'd0, 32'd0};
    run_block("wrap_neg");
    chk("wrap_neg_k11", c_11, 32'hFFFF_FFFE);
    av = '{32'h0001_0000, 32'd0, 32'd0, 32'd0};
    bv = '{32'h0001_0000, 32'd0, 32'd0, 32'd0};
    run_block("wrap_trunc");
    chk("wrap_trunc_k11", c_11, 32'd0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      run_block("rand");
    end

    // start_mac held high for 30 cycles: exactly one result
    rand_ops();
    snap();
    start_mac = 1'b1;
    done_cnt  = 0;
    repeat (30) begin
      tick();
      if (done_mac) done_cnt++;
    end
    start_mac = 1'b0;
    repeat (5) begin
      tick();
      if (done_mac) done_cnt++;
    end
    chk("held_done_cnt", 32'(done_cnt), 32'd1);
    check_c("held");

    // Operand change at E3, ignored pulse at E5, accepted pulse at E11
    rand_ops();
    snap();
    start_mac = 1'b1;
    tick();
    start_mac = 1'b0;
    done_cnt  = 0;
    done_at   = -1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (done_mac) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 3) begin
        av = '{32'd0, 32'd0, 32'd0, 32'd0};
        bv = '{32'd0, 32'd0, 32'd0, 32'd0};
      end
      if (k == 4) start_mac = 1'b1;
      if (k == 5) start_mac = 1'b0;
      if (k == 10) begin
        chk("chg_done_e10", 32'(done_mac), 32'd1);
        check_c("chg");
        rand_ops();
        start_mac = 1'b1;
      end
      if (k == 11) begin
        start_mac = 1'b0;
        snap();
        chk("retrig_busy_e11", 32'(busy), 32'd1);
      end
    end
    chk("retrig_done_cnt", 32'(done_cnt), 32'd2);
    chk("retrig_done_at", 32'(done_at), 32'd21);
    check_c("retrig");

    // Asynchronous reset mid-operation, released with start_mac high
    rand_ops();
    snap();
    start_mac = 1'b1;
    tick();
    start_mac = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done_mac), 32'd0);
    chk("arst_c11", c_11, 32'd0);
    chk("arst_c12", c_12, 32'd0);
    chk("arst_c21", c_21, 32'd0);
    chk("arst_c22", c_22, 32'd0);
    start_mac = 1'b1;
    tick();
    tick();
    chk("arst_hold_done", 32'(done_mac), 32'd0);
    rand_ops();
    snap();
    #2 rst = 1'b0;
    tick();
    chk("rel_busy_e0", 32'(busy), 32'd1);
    done_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done_mac) begin
        done_cnt++;
        done_at = k;
      end
    end
    start_mac = 1'b0;
    chk("rel_done_at", 32'(done_at), 32'd10);
    chk("rel_done_cnt", 32'(done_cnt), 32'd1);
    check_c("rel");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
